// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit cache-side read/write into two 16-bit
// accesses (low half-word first) on a 256K x 16 asynchronous SRAM, owning
// the SRAM pins and the tri-state data bus.
// Optional feature macro: SRAM_WAIT_CYCLE_EN inserts one wait cycle after
// each access cycle for slow SRAM parts (latency 5 instead of 3).
// All SRAM pins are driven from registers; no request input reaches them
// combinationally.
`default_nettype none

module sram_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_en,
  input  logic        write_en,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

`ifdef SRAM_WAIT_CYCLE_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_LO  = 3'd1,
    WAIT_LO = 3'd2,
    ACC_HI  = 3'd3,
    WAIT_HI = 3'd4,
    DONE    = 3'd5
  } state_t;
  // Last cycle of each half-word phase is the wait cycle.
  localparam state_t LO_LAST = WAIT_LO;
  localparam state_t HI_LAST = WAIT_HI;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;
  localparam state_t LO_LAST = ACC_LO;
  localparam state_t HI_LAST = ACC_HI;
`endif

  // SRAM half-word address of one half of a word.
  function automatic logic [17:0] half_addr(input logic [16:0] word, input logic half);
    return {word, half};
  endfunction

  state_t      state_r;
  logic [16:0] word_r;
  logic        is_write_r;
  logic [15:0] wdata_hi_r;
  logic [15:0] dq_out_r;
  logic        dq_oe_r;
  logic [31:0] read_data_r;
  logic        ready_r;
  logic [17:0] addr_r;
  logic        we_n_r;
  logic        oe_n_r;

  // Word index relative to the data region; modulo 2^32 below the base,
  // and only the low 17 word bits fit the 512 KB part.
  logic [31:0] diff_s;
  logic [16:0] word_s;
  logic        unused_bits_s;

  assign diff_s        = address - BASE_ADDR;
  assign word_s        = diff_s[18:2];
  assign unused_bits_s = ^{diff_s[31:19], diff_s[1:0]};

  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bz;
  assign SRAM_ADDR = addr_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = read_data_r;
  assign ready     = ready_r;

  // Access sequencer: latches the request in IDLE and steps through the two half-word phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      word_r      <= 17'd0;
      is_write_r  <= 1'b0;
      wdata_hi_r  <= 16'd0;
      dq_out_r    <= 16'd0;
      dq_oe_r     <= 1'b0;
      read_data_r <= 32'd0;
      ready_r     <= 1'b0;
      addr_r      <= 18'd0;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (write_en || read_en) begin
            // Write wins when both enables are raised together.
            state_r    <= ACC_LO;
            word_r     <= word_s;
            is_write_r <= write_en;
            wdata_hi_r <= write_data[31:16];
            dq_out_r   <= write_data[15:0];
            dq_oe_r    <= write_en;
            we_n_r     <= ~write_en;
            oe_n_r     <= write_en;
            addr_r     <= half_addr(word_s, 1'b0);
          end
        end
`ifdef SRAM_WAIT_CYCLE_EN
        ACC_LO: begin
          state_r <= WAIT_LO;
        end
        ACC_HI: begin
          state_r <= WAIT_HI;
        end
`endif
        LO_LAST: begin
          state_r  <= ACC_HI;
          addr_r   <= half_addr(word_r, 1'b1);
          dq_out_r <= wdata_hi_r;
          if (!is_write_r) begin
            read_data_r[15:0] <= SRAM_DQ;
          end
        end
        HI_LAST: begin
          state_r <= DONE;
          ready_r <= 1'b1;
          we_n_r  <= 1'b1;
          oe_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
          if (!is_write_r) begin
            read_data_r[31:16] <= SRAM_DQ;
          end
        end
        DONE: begin
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          we_n_r  <= 1'b1;
          oe_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed scenarios followed by
// randomized requests, checked against a half-word-addressed memory model.
module tb_sram_controller;

`ifdef SRAM_WAIT_CYCLE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  localparam int PH = (LAT - 1) / 2;  // cycles spent on each half-word

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        read_en;
  logic        write_en;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_en(read_en), .write_en(write_en), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Background content of a never-written SRAM location.
  function automatic logic [15:0] init_val(input int unsigned h);
    return 16'(h * 40503 + 7);
  endfunction

  // Asynchronous SRAM model: reads while OE_N low, writes while WE_N low.
  logic [15:0] mem [0:262143];
  bit          mem_ready = 1'b0;
  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 262144; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (!we_n) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  // Reference model: expected SRAM contents per half-word and last read word.
  logic [15:0] hmem [int unsigned];
  logic [31:0] last_rd = 32'd0;
  logic [17:0] obs_lo, obs_hi;

  function automatic int unsigned lo_half(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - 32'd1024) >> 2) % 32'd131072;
    return 2 * w;
  endfunction

  function automatic logic [15:0] ref_half(input int unsigned h);
    return hmem.exists(h) ? hmem[h] : init_val(h);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    read_en = 1'b0;
    write_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("ready_idle", {31'd0, ready}, 32'd1 & 32'd0);
    end
  endtask

  // Issue one request at a negedge; skip = cycles before the DUT can sample it.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int skip, input bit scramble);
    int c, i, half;
    int unsigned lo;
    logic [31:0] exp_rd;
    lo = lo_half(a);
    read_en = rd; write_en = wr; address = a; write_data = wd;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      i = c - skip;
      if (i >= 1 && i <= LAT - 1) begin
        half = (i - 1) / PH;
        check("sram_addr", {14'd0, sram_addr}, 32'(lo + half));
        if (i == 1) obs_lo = sram_addr;
        obs_hi = sram_addr;
        if (wr) begin
          check("we_n_wr", {31'd0, we_n}, 32'd0);
          check("oe_n_wr", {31'd0, oe_n}, 32'd1);
          check("dq_wr", {16'd0, sram_dq}, {16'd0, half ? wd[31:16] : wd[15:0]});
        end else begin
          check("we_n_rd", {31'd0, we_n}, 32'd1);
          check("oe_n_rd", {31'd0, oe_n}, 32'd0);
        end
      end
      if (scramble && i == 1) begin
        address = $urandom; write_data = $urandom;
        read_en = 1'($urandom); write_en = 1'($urandom);
      end
    end while (!ready && c < 30);
    check("latency", c, LAT + skip);
    check("done_we_n", {31'd0, we_n}, 32'd1);
    check("done_oe_n", {31'd0, oe_n}, 32'd1);
    check("done_addr", {14'd0, sram_addr}, 32'(lo + 1));
    if (wr) begin
      hmem[lo] = wd[15:0];
      hmem[lo + 1] = wd[31:16];
      check("rd_unchanged", read_data, last_rd);
    end else begin
      exp_rd = {ref_half(lo + 1), ref_half(lo)};
      last_rd = exp_rd;
      check("read_data", read_data, exp_rd);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int op;
    rst = 1'b0; address = 32'd0; write_data = 32'd0; read_en = 1'b0; write_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", {31'd0, we_n}, 32'd1);
    check("rst_oe_n", {31'd0, oe_n}, 32'd1);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("tied_pins", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
    rst = 1'b1;
    idle(2);

    // Write then read back the first word of the data region.
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 0, 1'b0);
    idle(1);
    check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 0, 1'b0);
    check("deadbeef", read_data, 32'hDEADBEEF);
    idle(1);

    // Reset in the first high-half cycle of a write.
    write_en = 1'b1; address = 32'd1044; write_data = 32'h12345678;
    repeat (PH + 1) @(negedge clk);
    check("pre_rst_we_n", {31'd0, we_n}, 32'd0);
    check("pre_rst_addr", {14'd0, sram_addr}, 32'd11);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_read_data", read_data, 32'd0);
    check("mid_rst_we_n", {31'd0, we_n}, 32'd1);
    check("mid_rst_oe_n", {31'd0, oe_n}, 32'd1);
    check("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
    write_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b1;
    hmem[10] = 16'h5678;
    last_rd = 32'd0;
    idle(2);
    access(1'b1, 1'b0, 32'd1044, 32'd0, 0, 1'b0);
    idle(1);

    // Held read_en: back-to-back reads at 1032 then 1036.
    access(1'b1, 1'b0, 32'd1032, 32'd0, 0, 1'b0);
    check("b2b_first_lo", {14'd0, obs_lo}, 32'd4);
    access(1'b1, 1'b0, 32'd1036, 32'd0, 1, 1'b0);
    check("b2b_second_lo", {14'd0, obs_lo}, 32'd6);
    check("b2b_second_hi", {14'd0, obs_hi}, 32'd7);
    idle(1);

    // Both enables raised: treated as a write.
    access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 0, 1'b0);
    idle(1);
    check("both_mem2", {16'd0, mem[2]}, 32'h0000F00D);
    check("both_mem3", {16'd0, mem[3]}, 32'h0000CAFE);

    // Address just below the base wraps to the top of the SRAM.
    access(1'b0, 1'b1, 32'd1020, 32'h0BADCAFE, 0, 1'b0);
    check("wrap_lo", {14'd0, obs_lo}, 32'h0003FFFE);
    check("wrap_hi", {14'd0, obs_hi}, 32'h0003FFFF);
    idle(1);
    access(1'b1, 1'b0, 32'd1020, 32'd0, 0, 1'b0);
    idle(1);

    // Randomized mix, mostly inside a small window so reads hit written data.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      d = $urandom;
      access(op != 1, op != 0, a, d, 0, 1'($urandom));
      idle($urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
